// File: rtl/apb_cmd_master.sv
// Command-to-APB bridge: accepts one read/write command at a time, runs the
// SETUP/ACCESS handshake, and returns a one-cycle response with optional timeout.
module apb_cmd_master #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    // Count value held during the last permitted wait cycle
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        wait_q;
    logic                    cmd_ready_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    rsp_timeout_q;
    logic                    psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q       <= ST_IDLE;
            wait_q        <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        state_q     <= ST_SETUP;
                        cmd_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        pwrite_q    <= cmd_write;
                        paddr_q     <= cmd_addr;
                        pwdata_q    <= cmd_write ? cmd_wdata : '0;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                    wait_q    <= '0;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= PSLVERR;
                        if (!pwrite_q) begin
                            rsp_rdata_q <= PRDATA;
                        end
                    end else if ((TIMEOUT != 0) && (wait_q == CNT_LAST)) begin
                        state_q       <= ST_IDLE;
                        cmd_ready_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                    end else if (wait_q != '1) begin
                        // Saturate rather than wrap when timeout is disabled
                        wait_q <= wait_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: transaction-level timing model, a scripted
// APB slave, per-cycle comparison and literal checks on key scenarios.
module tb_apb_cmd_master;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int TO  = 16;
    localparam int NTX = 10;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    apb_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // ws = PREADY-low ACCESS cycles before the slave answers; ws >= TO never answers
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] prdata;
        logic          slverr;
        int            ws;
        int            gap;
    } tx_t;

    tx_t tbl[NTX];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted command occupies the bus from its
    // accept edge until accept+2+waits, or accept+TO+1 when the slave stalls.
    int            cyc = 0;
    bit            m_ready = 0, m_busy = 0, m_rsp = 0, m_err = 0, m_to = 0;
    int            m_start = 0, m_end = 0, m_idx = 0, drv_idx = 0, n_acc = 0;
    logic          m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;

    always @(posedge PCLK) begin
        cyc++;
        if (PRESET) begin
            m_ready = 0; m_busy = 0; m_rsp = 0; m_err = 0; m_to = 0;
            m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else begin
            m_rsp = 0; m_err = 0; m_to = 0;
            if (m_busy) begin
                if (cyc == m_end) begin
                    m_busy = 0; m_rsp = 1; m_ready = 1;
                    if (tbl[m_idx].ws >= TO) begin
                        m_err = 1; m_to = 1;
                    end else begin
                        m_err = tbl[m_idx].slverr;
                        if (!m_wr) m_rdata = tbl[m_idx].prdata;
                    end
                end
            end else if (m_ready && cmd_valid) begin
                m_busy = 1; m_ready = 0; m_idx = drv_idx; n_acc++;
                m_wr = cmd_write; m_addr = cmd_addr;
                m_wdata = cmd_write ? cmd_wdata : '0;
                m_start = cyc;
                m_end = cyc + 2 + ((tbl[drv_idx].ws >= TO) ? TO - 1 : tbl[drv_idx].ws);
            end else begin
                m_ready = 1;
            end
        end
    end

    // Scripted slave: answers on the (ws+1)-th ACCESS cycle, garbage otherwise
    int acc = 0;
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) acc++; else acc = 0;
        if (PSEL && PENABLE && acc > tbl[m_idx].ws) begin
            PREADY = 1'b1; PRDATA = tbl[m_idx].prdata; PSLVERR = tbl[m_idx].slverr;
        end else begin
            PREADY = 1'b0; PRDATA = DW'($urandom); PSLVERR = 1'($urandom);
        end
    end

    int psel_cnt[NTX], pen_cnt[NTX], setup_cyc[NTX], rsp_cyc[NTX];
    logic obs_err[NTX], obs_to[NTX];
    logic [DW-1:0] obs_rd[NTX];
    int n_rsp = 0;

    always @(negedge PCLK) begin
        chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
        chk("PSEL", 32'(PSEL), 32'(m_busy));
        chk("PENABLE", 32'(PENABLE), 32'(m_busy && (cyc > m_start)));
        chk("PWRITE", 32'(PWRITE), 32'(m_wr));
        chk("PADDR", 32'(PADDR), 32'(m_addr));
        chk("PWDATA", 32'(PWDATA), 32'(m_wdata));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        if (m_rsp) begin
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
        end
        if (PSEL) psel_cnt[m_idx]++;
        if (PENABLE) pen_cnt[m_idx]++;
        if (PSEL && !PENABLE) setup_cyc[m_idx] = cyc;
        if (rsp_valid) begin
            n_rsp++;
            rsp_cyc[m_idx] = cyc;
            obs_err[m_idx] = rsp_err;
            obs_to[m_idx] = rsp_timeout;
            obs_rd[m_idx] = rsp_rdata;
        end
    end

    task automatic set_tx(input int i, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] prdata,
                          input logic slverr, input int ws, input int gap);
        tbl[i].wr = wr; tbl[i].addr = addr; tbl[i].wdata = wdata;
        tbl[i].prdata = prdata; tbl[i].slverr = slverr; tbl[i].ws = ws; tbl[i].gap = gap;
    endtask

    // Present a command, hold until accepted, then optionally idle with junk on cmd_*
    task automatic send(input int i);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = tbl[i].wr; cmd_addr = tbl[i].addr;
        cmd_wdata = tbl[i].wdata; drv_idx = i;
        while (!cmd_ready && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        chk("accept_wait_bound", 32'(n >= 100), 32'd0);
        @(negedge PCLK);
        if (tbl[i].gap > 0) begin
            cmd_valid = 1'b0; cmd_write = 1'($urandom);
            cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
            repeat (tbl[i].gap) @(negedge PCLK);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NTX; i++) begin
            psel_cnt[i] = 0; pen_cnt[i] = 0; setup_cyc[i] = -1; rsp_cyc[i] = -1;
            obs_err[i] = 1'b0; obs_to[i] = 1'b0; obs_rd[i] = '0;
        end
        //         idx wr    addr   wdata  prdata slverr ws  gap
        set_tx(0, 1'b1, 8'h00, 8'hB3, 8'h00, 1'b0, 0,  2);
        set_tx(1, 1'b0, 8'h03, 8'h00, 8'h5A, 1'b0, 3,  1);
        set_tx(2, 1'b1, 8'h55, 8'h21, 8'h00, 1'b1, 1,  1);
        set_tx(3, 1'b0, 8'h10, 8'h00, 8'hEE, 1'b0, 99, 0);
        set_tx(4, 1'b1, 8'h20, 8'h44, 8'h00, 1'b0, 0,  0);
        set_tx(5, 1'b0, 8'h21, 8'h00, 8'h99, 1'b0, 0,  0);
        set_tx(6, 1'b0, 8'h22, 8'h00, 8'h77, 1'b0, 15, 1);
        set_tx(7, 1'b0, 8'h30, 8'h00, 8'hC3, 1'b1, 2,  1);
        set_tx(8, 1'b0, 8'h40, 8'h00, 8'hAB, 1'b0, 10, 0);
        set_tx(9, 1'b1, 8'h41, 8'h12, 8'h00, 1'b0, 0,  3);

        repeat (3) @(negedge PCLK);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        PRESET = 1'b0;
        for (int i = 0; i < 8; i++) send(i);

        // Abort a stalled read with an asynchronous reset mid-ACCESS
        send(8);
        cmd_valid = 1'b0;
        repeat (4) @(negedge PCLK);
        chk("pre_reset_penable", 32'(PENABLE), 32'd1);
        #2 PRESET = 1'b1;
        #1;
        chk("async_rst_PSEL", 32'(PSEL), 32'd0);
        chk("async_rst_PENABLE", 32'(PENABLE), 32'd0);
        chk("async_rst_PADDR", 32'(PADDR), 32'd0);
        chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        @(negedge PCLK);
        #2 PRESET = 1'b0;
        @(negedge PCLK);
        chk("ready_after_release", 32'(cmd_ready), 32'd1);
        send(9);
        repeat (10) @(negedge PCLK);

        chk("wr0_psel_cycles", 32'(psel_cnt[0]), 32'd2);
        chk("wr0_penable_cycles", 32'(pen_cnt[0]), 32'd1);
        chk("wr0_latency", 32'(rsp_cyc[0] - setup_cyc[0]), 32'd2);
        chk("wr0_err", 32'(obs_err[0]), 32'd0);
        chk("rd1_penable_cycles", 32'(pen_cnt[1]), 32'd4);
        chk("rd1_rdata", 32'(obs_rd[1]), 32'h5A);
        chk("rd1_err", 32'(obs_err[1]), 32'd0);
        chk("wr2_err", 32'(obs_err[2]), 32'd1);
        chk("wr2_timeout", 32'(obs_to[2]), 32'd0);
        chk("to3_penable_cycles", 32'(pen_cnt[3]), 32'd16);
        chk("to3_err", 32'(obs_err[3]), 32'd1);
        chk("to3_timeout", 32'(obs_to[3]), 32'd1);
        chk("to3_rdata_held", 32'(obs_rd[3]), 32'h5A);
        chk("to3_latency", 32'(rsp_cyc[3] - setup_cyc[3]), 32'd17);
        chk("b2b_after_timeout", 32'(setup_cyc[4] - rsp_cyc[3]), 32'd1);
        chk("b2b_after_write", 32'(setup_cyc[5] - rsp_cyc[4]), 32'd1);
        chk("rd6_edge_no_timeout", 32'(obs_to[6]), 32'd0);
        chk("rd6_rdata", 32'(obs_rd[6]), 32'h77);
        chk("rd6_penable_cycles", 32'(pen_cnt[6]), 32'd16);
        chk("rd7_rdata_with_err", 32'(obs_rd[7]), 32'hC3);
        chk("rd7_err", 32'(obs_err[7]), 32'd1);
        chk("aborted_no_rsp", 32'(rsp_cyc[8]), 32'hFFFF_FFFF);
        chk("wr9_rdata_after_reset", 32'(obs_rd[9]), 32'd0);
        chk("wr9_psel_cycles", 32'(psel_cnt[9]), 32'd2);
        chk("rsp_count", 32'(n_rsp), 32'd9);
        chk("accept_count", 32'(n_acc), 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
